// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, alignment/range/funct3 checks,
// byte-lane steering for stores and sign/zero extension of 1-cycle-latency loads.
module load_store_unit #(
    parameter int unsigned DMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        store_done,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_sdata,
    output logic        mem_lenable,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_ldata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DMEM_SIZE * 32'd4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_LWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  sel_q, sel_d;
    logic [4:0]  rd_q, rd_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        store_done_q, store_done_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_sdata_q, mem_sdata_d;
    logic        mem_lenable_q, mem_lenable_d;
    logic [3:0]  mem_mask_q, mem_mask_d;

    logic        illegal_s, misaligned_s, out_of_range_s, reject_s;
    logic [3:0]  st_mask_s;
    logic [31:0] st_data_s;
    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;
    logic [31:0] ld_ext_s;

    // Legality of the request currently presented on the request port
    always_comb begin
        illegal_s      = 1'b0;
        misaligned_s   = 1'b0;
        if (req_we) begin
            illegal_s = (req_funct3 > 3'd2);
        end else begin
            illegal_s = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned_s = req_addr[0];
            2'b10:   misaligned_s = (req_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        out_of_range_s = (req_addr >= ADDR_LIMIT);
        reject_s       = illegal_s || misaligned_s || out_of_range_s;
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        st_mask_s = 4'b0000;
        st_data_s = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_mask_s = 4'b0001 << req_addr[1:0];
                st_data_s = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask_s = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data_s = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                st_mask_s = 4'b1111;
                st_data_s = req_wdata;
            end
            default: begin
                st_mask_s = 4'b0000;
                st_data_s = req_wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        ld_byte_s = mem_ldata[{sel_q, 3'b000} +: 8];
        ld_half_s = mem_ldata[{sel_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    ld_ext_s = {{24{ld_byte_s[7]}}, ld_byte_s};
            3'd1:    ld_ext_s = {{16{ld_half_s[15]}}, ld_half_s};
            3'd4:    ld_ext_s = {24'd0, ld_byte_s};
            3'd5:    ld_ext_s = {16'd0, ld_half_s};
            default: ld_ext_s = mem_ldata;
        endcase
    end

    // Next-state and output-register logic; bus strobes and pulses default low
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        sel_d         = sel_q;
        rd_d          = rd_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        resp_rd_d     = resp_rd_q;
        store_done_d  = 1'b0;
        err_d         = 1'b0;
        err_addr_d    = err_addr_q;
        mem_addr_d    = mem_addr_q;
        mem_sdata_d   = mem_sdata_q;
        mem_lenable_d = 1'b0;
        mem_mask_d    = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    sel_d    = req_addr[1:0];
                    rd_d     = req_rd;
                    if (reject_s) begin
                        err_d      = 1'b1;
                        err_addr_d = req_addr;
                    end else if (req_we) begin
                        mem_addr_d   = req_addr;
                        mem_sdata_d  = st_data_s;
                        mem_mask_d   = st_mask_s;
                        store_done_d = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
                        mem_addr_d    = req_addr;
                        mem_lenable_d = 1'b1;
                        state_d       = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = we_q ? S_IDLE : S_LWAIT;
            S_LWAIT: begin
                resp_valid_d = 1'b1;
                resp_data_d  = ld_ext_s;
                resp_rd_d    = rd_q;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            sel_q         <= 2'd0;
            rd_q          <= 5'd0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'd0;
            resp_rd_q     <= 5'd0;
            store_done_q  <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= 32'd0;
            mem_addr_q    <= 32'd0;
            mem_sdata_q   <= 32'd0;
            mem_lenable_q <= 1'b0;
            mem_mask_q    <= 4'b0000;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            sel_q         <= sel_d;
            rd_q          <= rd_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_rd_q     <= resp_rd_d;
            store_done_q  <= store_done_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
            mem_addr_q    <= mem_addr_d;
            mem_sdata_q   <= mem_sdata_d;
            mem_lenable_q <= mem_lenable_d;
            mem_mask_q    <= mem_mask_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_rd     = resp_rd_q;
    assign store_done  = store_done_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_sdata   = mem_sdata_q;
    assign mem_lenable = mem_lenable_q;
    assign mem_mask    = mem_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory model, directed
// vector table, randomized requests, back-to-back and reset-in-flight sequences.
module tb_load_store_unit;

    localparam int unsigned DMEM_SIZE = 4096;
    localparam int unsigned NBYTES    = DMEM_SIZE * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        store_done, err;
    logic [31:0] err_addr, mem_addr, mem_sdata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;
    logic [31:0] mem_ldata;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_SIZE(DMEM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_rd(resp_rd), .store_done(store_done), .err(err), .err_addr(err_addr),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .mem_lenable(mem_lenable),
        .mem_mask(mem_mask), .mem_ldata(mem_ldata)
    );

    // Data memory: byte-masked writes, registered reads
    logic [31:0] dmem [0:DMEM_SIZE-1];
    always @(posedge clk) begin
        if (mem_lenable) mem_ldata <= dmem[mem_addr[13:2]];
        for (int b = 0; b < 4; b++)
            if (mem_mask[b]) dmem[mem_addr[13:2]][8*b +: 8] <= mem_sdata[8*b +: 8];
    end

    int cyc = 0;
    int len_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_lenable) len_cnt <= len_cnt + 1;
    end

    logic [7:0]  ref_b [0:NBYTES-1];
    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_err_addr = 32'd0, exp_resp_data = 32'd0;
    logic [4:0]  exp_resp_rd = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if (addr >= NBYTES) return 1'b1;
        return (addr % 32'(size_of(f3))) != 32'd0;
    endfunction

    // Little-endian gather from the byte model, then extend by access size
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v = 0;
        int n = size_of(f3);
        for (int i = 0; i < n; i++) v += longint'(ref_b[addr + 32'(i)]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < size_of(f3); i++) ref_b[addr + 32'(i)] = wdata[8*i +: 8];
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic exp_bad, input logic [31:0] exp_data);
        int n;
        int sz;
        logic [3:0]  em;
        logic [31:0] es;
        es = 32'd0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_bad) begin
            exp_err_addr = addr;
            chk("rej_pulses", {28'd0, err, store_done, mem_lenable, resp_valid}, 32'h8);
            chk("rej_mask", {28'd0, mem_mask}, 32'd0);
            chk("rej_err_addr", err_addr, addr);
            @(negedge clk);
            chk("rej_idle", {28'd0, req_ready, err, mem_lenable, store_done}, 32'h8);
        end else if (we) begin
            sz = size_of(f3);
            em = 4'(((1 << sz) - 1) << addr[1:0]);
            for (int l = 0; l < 4; l++) es[8*l +: 8] = wdata[8*(l % sz) +: 8];
            chk("st_pulses", {28'd0, store_done, err, mem_lenable, resp_valid}, 32'h8);
            chk("st_mask", {28'd0, mem_mask}, {28'd0, em});
            chk("st_sdata", mem_sdata, es);
            chk("st_addr", mem_addr, addr);
            chk("resp_hold", {resp_data[31:5], resp_data[4:0] ^ resp_rd}, {exp_resp_data[31:5], exp_resp_data[4:0] ^ exp_resp_rd});
            model_store(f3, addr, wdata);
            @(negedge clk);
            chk("st_idle", {26'd0, req_ready, store_done, mem_mask}, 32'h20);
        end else begin
            chk("ld_issue", {27'd0, mem_lenable, mem_mask}, 32'h10);
            chk("ld_addr", mem_addr, addr);
            @(negedge clk);
            chk("ld_wait", {30'd0, mem_lenable, resp_valid}, 32'd0);
            @(negedge clk);
            chk("ld_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("ld_data", resp_data, exp_data);
            chk("ld_rd", {27'd0, resp_rd}, {27'd0, rd});
            exp_resp_data = exp_data;
            exp_resp_rd   = rd;
            @(negedge clk);
            chk("ld_idle", {30'd0, req_ready, resp_valid}, 32'h2);
        end
        chk("err_addr_hold", err_addr, exp_err_addr);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        bad;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, len0;
        int acc [3];
        logic [31:0] ba [3];
        logic        we, bad;
        logic [2:0]  f3;
        logic [31:0] addr, ed;

        tbl[0]  = '{1'b1, 3'd2, 32'h100,  32'h11223344, 5'd0,  1'b0, 32'h0};
        tbl[1]  = '{1'b1, 3'd0, 32'h103,  32'h000000A5, 5'd0,  1'b0, 32'h0};
        tbl[2]  = '{1'b0, 3'd2, 32'h100,  32'h0,        5'd7,  1'b0, 32'hA5223344};
        tbl[3]  = '{1'b1, 3'd2, 32'h200,  32'h80FF7F01, 5'd0,  1'b0, 32'h0};
        tbl[4]  = '{1'b0, 3'd0, 32'h203,  32'h0,        5'd1,  1'b0, 32'hFFFFFF80};
        tbl[5]  = '{1'b0, 3'd4, 32'h203,  32'h0,        5'd2,  1'b0, 32'h00000080};
        tbl[6]  = '{1'b0, 3'd1, 32'h202,  32'h0,        5'd3,  1'b0, 32'hFFFF80FF};
        tbl[7]  = '{1'b0, 3'd5, 32'h202,  32'h0,        5'd4,  1'b0, 32'h000080FF};
        tbl[8]  = '{1'b0, 3'd2, 32'h200,  32'h0,        5'd5,  1'b0, 32'h80FF7F01};
        tbl[9]  = '{1'b0, 3'd0, 32'h201,  32'h0,        5'd6,  1'b0, 32'h0000007F};
        tbl[10] = '{1'b0, 3'd5, 32'h200,  32'h0,        5'd8,  1'b0, 32'h00007F01};
        tbl[11] = '{1'b0, 3'd2, 32'h102,  32'h0,        5'd9,  1'b1, 32'h0};
        tbl[12] = '{1'b1, 3'd1, 32'h001,  32'h1234,     5'd0,  1'b1, 32'h0};
        tbl[13] = '{1'b1, 3'd0, 32'h4000, 32'h55,       5'd0,  1'b1, 32'h0};
        tbl[14] = '{1'b0, 3'd3, 32'h100,  32'h0,        5'd10, 1'b1, 32'h0};
        tbl[15] = '{1'b1, 3'd4, 32'h100,  32'h66,       5'd0,  1'b1, 32'h0};
        tbl[16] = '{1'b1, 3'd2, 32'h3FFC, 32'h12345678, 5'd0,  1'b0, 32'h0};
        tbl[17] = '{1'b0, 3'd0, 32'h3FFF, 32'h0,        5'd11, 1'b0, 32'h00000012};
        tbl[18] = '{1'b0, 3'd1, 32'h3FFE, 32'h0,        5'd12, 1'b0, 32'h00001234};
        tbl[19] = '{1'b0, 3'd5, 32'h3FFF, 32'h0,        5'd13, 1'b1, 32'h0};
        tbl[20] = '{1'b1, 3'd1, 32'h202,  32'hBEEF9876, 5'd0,  1'b0, 32'h0};
        tbl[21] = '{1'b0, 3'd1, 32'h202,  32'h0,        5'd14, 1'b0, 32'hFFFF9876};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {23'd0, req_ready, resp_valid, store_done, err, mem_lenable, mem_mask}, 32'h100);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_sdata", mem_sdata, 32'd0);
        chk("rst_resp", resp_data | {27'd0, resp_rd}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        rst = 1'b0;

        // Fill the low 1 KiB so random loads read defined data
        for (int i = 0; i < 256; i++) issue(1'b1, 3'd2, 32'(i * 4), $urandom, 5'd0, 1'b0, 32'd0);

        for (int i = 0; i < 22; i++)
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].bad, tbl[i].exp);

        for (int i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h4000) : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC;
            bad  = model_bad(we, f3, addr);
            ed   = (!we && !bad) ? model_load(f3, addr) : 32'd0;
            issue(we, f3, addr, $urandom, 5'($urandom_range(0, 31)), bad, ed);
        end

        // Three loads with req_valid held high
        ba[0] = 32'h200; ba[1] = 32'h104; ba[2] = 32'h3FFC;
        @(negedge clk);
        len0 = len_cnt;
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = ba[0]; req_rd = 5'd20; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!req_ready && n < 10) begin @(negedge clk); n++; end
            chk("bb_ready", {31'd0, req_ready}, 32'd1);
            acc[k] = cyc;
            @(negedge clk);
            if (k < 2) begin req_addr = ba[k+1]; req_rd = 5'(21 + k); end
            else req_valid = 1'b0;
            chk("bb_busy1", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk("bb_busy2", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk("bb_busy3", {31'd0, req_ready}, 32'd0);
            chk("bb_resp", {26'd0, resp_valid, resp_rd}, {26'd0, 1'b1, 5'(20 + k)});
            chk("bb_data", resp_data, model_load(3'd2, ba[k]));
            exp_resp_data = model_load(3'd2, ba[k]);
            exp_resp_rd   = 5'(20 + k);
        end
        @(negedge clk);
        chk("bb_spacing01", 32'(acc[1] - acc[0]), 32'd4);
        chk("bb_spacing12", 32'(acc[2] - acc[1]), 32'd4);
        chk("bb_lenable_count", 32'(len_cnt - len0), 32'd3);

        // Reset in the LWAIT cycle of a load, with a store presented under reset
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_rd = 5'd30; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h55555555; req_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {23'd0, req_ready, resp_valid, store_done, err, mem_lenable, mem_mask}, 32'h100);
        chk("rst_mid_resp", resp_data, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        exp_resp_data = 32'd0; exp_resp_rd = 5'd0; exp_err_addr = 32'd0;
        @(negedge clk);
        chk("rst_after", {23'd0, req_ready, resp_valid, store_done, err, mem_lenable, mem_mask}, 32'h100);
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0);
        issue(1'b0, 3'd2, 32'h10, 32'd0, 5'd31, 1'b0, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
